// File: rtl/xpb_pkg.sv
// Shared defaults and state encoding for the xpb reduction-table generator.
package xpb_pkg;

  localparam int DIGIT_BITS_DEF = 5;
  localparam int WORD_W_DEF     = 1024;
  localparam int LIMB_W_DEF     = 64;
  localparam int NLIMB_DEF      = WORD_W_DEF / LIMB_W_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR0   = 3'd1,
    ADD   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } xpb_gen_state_t;

endpackage

// File: rtl/xpb_table_gen_limb_addsub.sv
// One limb of the serial modular adder: s = a + b + cin, then d = s - m - bin,
// both with carry/borrow out so limbs can be chained across cycles.
module limb_addsub #(
  parameter int LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic [LIMB_W-1:0] m,
  input  logic              cin,
  input  logic              bin,
  output logic [LIMB_W-1:0] s,
  output logic              cout,
  output logic [LIMB_W-1:0] d,
  output logic              bout
);

  logic [LIMB_W:0] sum_w;
  logic [LIMB_W:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
  assign s      = sum_w[LIMB_W-1:0];
  assign cout   = sum_w[LIMB_W];

  // The extra top bit of the widened subtraction is the borrow out.
  assign diff_w = {1'b0, s} - {1'b0, m} - {{LIMB_W{1'b0}}, bin};
  assign d      = diff_w[LIMB_W-1:0];
  assign bout   = diff_w[LIMB_W];

endmodule

// File: rtl/xpb_table_gen.sv
// Fills the 2^DIGIT_BITS-entry table k*base mod M by repeated modular addition,
// one limb per cycle, writing each entry through a RAM-style port.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int DIGIT_BITS = DIGIT_BITS_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int LIMB_W     = LIMB_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_W-1:0]     base_in,
  input  logic [WORD_W-1:0]     mod_in,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [DIGIT_BITS-1:0] wr_addr,
  output logic [WORD_W-1:0]     wr_data
);

  localparam int NLIMB = WORD_W / LIMB_W;
  localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  localparam logic [DIGIT_BITS-1:0] K_LAST = '1;
  localparam logic [IW-1:0]         I_LAST = IW'(NLIMB - 1);

  xpb_gen_state_t state;

  logic [WORD_W-1:0]     base_r;
  logic [WORD_W-1:0]     mod_r;
  logic [WORD_W-1:0]     acc;
  logic [WORD_W-1:0]     sum_r;
  logic [WORD_W-1:0]     diff_r;
  logic [DIGIT_BITS-1:0] k;
  logic [IW-1:0]         i;
  logic                  c;
  logic                  b;

  logic [LIMB_W-1:0]     s_limb;
  logic [LIMB_W-1:0]     d_limb;
  logic                  cout;
  logic                  bout;
  logic [WORD_W-1:0]     result;

  // Every operand presents its current limb at bit 0; the registers shift or
  // rotate by one limb per ADD cycle, so no wide limb multiplexer is needed.
  limb_addsub #(.LIMB_W(LIMB_W)) u_addsub (
    .a    (acc[LIMB_W-1:0]),
    .b    (base_r[LIMB_W-1:0]),
    .m    (mod_r[LIMB_W-1:0]),
    .cin  (c),
    .bin  (b),
    .s    (s_limb),
    .cout (cout),
    .d    (d_limb),
    .bout (bout)
  );

  // acc < M holds, so acc+base < 2M: subtract once if the sum overflowed the
  // word or the subtraction did not borrow (sum >= M, including sum == M).
  assign result = (c || !b) ? diff_r : sum_r;

  // NOTE: all state here is sequential and updated with non-blocking
  // assignments; the wide data registers are reset too, so wr_data reads 0
  // after reset and no stale value can leak into a later write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_r  <= '0;
      mod_r   <= '0;
      acc     <= '0;
      sum_r   <= '0;
      diff_r  <= '0;
      k       <= '0;
      i       <= '0;
      c       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      busy  <= (state != IDLE);

      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base_in;
            mod_r  <= mod_in;
            acc    <= '0;
            k      <= '0;
            state  <= WR0;
          end
        end

        WR0: begin
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= '0;
          k       <= DIGIT_BITS'(1);
          i       <= '0;
          c       <= 1'b0;
          b       <= 1'b0;
          state   <= ADD;
        end

        ADD: begin
          // Results enter at the top so limb 0 lands at the bottom after NLIMB shifts;
          // base and modulus rotate back to their original alignment.
          sum_r  <= WORD_W'({s_limb, sum_r} >> LIMB_W);
          diff_r <= WORD_W'({d_limb, diff_r} >> LIMB_W);
          base_r <= WORD_W'({base_r[LIMB_W-1:0], base_r} >> LIMB_W);
          mod_r  <= WORD_W'({mod_r[LIMB_W-1:0], mod_r} >> LIMB_W);
          acc    <= acc >> LIMB_W;
          c      <= cout;
          b      <= bout;
          if (i == I_LAST) begin
            state <= WRITE;
          end else begin
            i <= i + IW'(1);
          end
        end

        WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= k;
          wr_data <= result;
          acc     <= result;
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            k     <= k + DIGIT_BITS'(1);
            i     <= '0;
            c     <= 1'b0;
            b     <= 1'b0;
            state <= ADD;
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: directed and random (base, M) pairs,
// each entry compared against k*base mod M computed directly.
module tb_xpb_table_gen;

  localparam int DB    = 5;
  localparam int W     = 1024;
  localparam int L     = 64;
  localparam int NL    = W / L;
  localparam int DEPTH = 1 << DB;
  localparam int STEP  = NL + 1;
  localparam int LAST_WR    = 1 + STEP * (DEPTH - 1);
  localparam int DONE_CYC   = LAST_WR + 1;
  localparam int RUN_CYCLES = DONE_CYC + 6;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  base_in;
  logic [W-1:0]  mod_in;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic [DB-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  int n_checks = 0;
  int n_errors = 0;

  xpb_table_gen #(.DIGIT_BITS(DB), .WORD_W(W), .LIMB_W(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base_in (base_in),
    .mod_in  (mod_in),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got ...%h expected ...%h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  // Reference: table entry computed straight from its definition.
  function automatic logic [W-1:0] ref_entry(input int k, input logic [W-1:0] base,
                                             input logic [W-1:0] m);
    logic [W+5:0] prod;
    prod = (W+6)'(k) * {6'b0, base};
    return W'(prod % {6'b0, m});
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < W / 32; j++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  W'(busy),    '0);
    check({tag, " done"},  W'(done),    '0);
    check({tag, " wr_en"}, W'(wr_en),   '0);
    check({tag, " addr"},  W'(wr_addr), '0);
    check({tag, " data"},  wr_data,     '0);
  endtask

  // One table run. retrig re-pulses start (with scrambled inputs) at cycles 5
  // and 300; abort_at > 0 drops rst_n just after that cycle's edge.
  task automatic run_seq(input string name, input logic [W-1:0] base, input logic [W-1:0] m,
                         input bit retrig, input int abort_at);
    int  idx;
    bit  exp_wr;
    @(negedge clk);
    base_in = base;
    mod_in  = m;
    start   = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= RUN_CYCLES; n++) begin
      @(negedge clk);
      start = retrig && (n == 5 || n == 300);
      if (retrig) begin
        base_in = rand_word();
        mod_in  = rand_word();
      end
      @(posedge clk);
      #1;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs($sformatf("%s rst", name));
        for (int r = 0; r < 16; r++) begin
          @(negedge clk);
          if (r == 8) rst_n = 1'b1;
          @(posedge clk);
          #1;
          check($sformatf("%s post-rst wr_en", name), W'(wr_en), '0);
          check($sformatf("%s post-rst busy", name),  W'(busy),  '0);
        end
        return;
      end
      idx    = (n - 1) / STEP;
      exp_wr = ((n - 1) % STEP == 0) && (idx < DEPTH);
      check($sformatf("%s c%0d wr_en", name, n), W'(wr_en), W'(exp_wr));
      check($sformatf("%s c%0d busy", name, n),  W'(busy),  W'(n >= 1 && n <= DONE_CYC));
      check($sformatf("%s c%0d done", name, n),  W'(done),  W'(n == DONE_CYC));
      if (exp_wr) begin
        check($sformatf("%s e%0d addr", name, idx), W'(wr_addr), W'(idx));
        check($sformatf("%s e%0d data", name, idx), wr_data, ref_entry(idx, base, m));
      end
    end
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] bs;
    rst_n   = 1'b0;
    start   = 1'b0;
    base_in = '0;
    mod_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("after release");

    run_seq("m97", W'(40), W'(97), 1'b0, 0);
    run_seq("m100", W'(50), W'(100), 1'b0, 0);

    m  = '1;
    bs = '0;
    bs[W-1] = 1'b1;
    run_seq("mmax", bs, m, 1'b0, 0);

    m = rand_word() | W'(1);
    run_seq("base0", '0, m, 1'b0, 0);

    m  = rand_word() | W'(1);
    bs = rand_word() % m;
    run_seq("retrig", bs, m, 1'b1, 0);

    m  = rand_word() | W'(1);
    bs = rand_word() % m;
    run_seq("abort", bs, m, 1'b0, 200);
    run_seq("fresh", bs, m, 1'b0, 0);

    for (int t = 0; t < 3; t++) begin
      m = rand_word();
      if (t == 0) m[W-1] = 1'b1;
      if (t == 2) m = W'($urandom_range(1000, 1));
      if (m == '0) m = W'(1);
      bs = rand_word() % m;
      run_seq($sformatf("rnd%0d", t), bs, m, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Sequential generator for the 32-entry xpb reduction table used by the modular-squaring datapath: entry k = (k · base) mod M, for k = 0..31. Given a precomputed base (e.g. 2^320 mod M) and modulus M, it produces the entries in order with a limb-serial modular adder. It writes them through a RAM-style write port. The table that the squarer's 5-bit digit lookup reads is filled by this block at configuration time instead of being hard-coded.

## Interface
- DIGIT_BITS, 5: table index width; table depth = 2^DIGIT_BITS.
- WORD_W, 1024: entry/modulus width.
- LIMB_W, 64: adder limb width; WORD_W must be a multiple of LIMB_W; NLIMB = WORD_W/LIMB_W.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_in  in  WORD_W  table step; must satisfy base_in < mod_in (not checked).
- mod_in  in  WORD_W  modulus M, M ≥ 1.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the last entry is written.
- wr_en  out  1  table write strobe.
- wr_addr  out  DIGIT_BITS  entry index k.
- wr_data  out  WORD_W  entry value.

## Operation
- States: IDLE, WR0, ADD, WRITE, DONE.
- IDLE: if start, latch base_in→base_r and mod_in→mod_r, clear acc, set k=0, go to WR0. Inputs are not resampled afterwards.
- WR0: wr_en=1, wr_addr=0, wr_data=0. Set k=1, clear limb index i, clear carry and borrow, then go to ADD.
- ADD, one limb per cycle for i = 0..NLIMB-1:
  - s_i = acc_i + base_i + c, with carry out to c.
  - d_i = s_i − mod_i − b, with borrow out to b.
  - Store s_i and d_i into the sum_r and diff_r shift registers.
  - After the last limb, go to WRITE.
- WRITE: result = diff_r if (c_final==1 or b_final==0), otherwise sum_r. Drive wr_en=1, wr_addr=k, wr_data=result, and set acc=result.
  - If k = 2^DIGIT_BITS−1, go to DONE.
  - Otherwise k++, clear i/c/b, and go to ADD.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: acc < M is invariant, so a single conditional subtraction is sufficient. The carry out of acc+base (possible when M > 2^(WORD_W−1)) forces the subtract path. A sum exactly equal to M yields 0.
- start while busy is ignored and has no effect on the running sequence.
- Reset at any time: return to IDLE and zero all outputs and registers. No partial write is issued after rst_n falls.

## Timing
- Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
- All outputs are registered.
- Cycle numbering: cycle 0 is the edge on which start is sampled.
  - Entry 0 is written in cycle 1.
  - Entry k (k ≥ 1) is written in cycle 1 + k·(NLIMB+1); with defaults, entry k is written in cycle 1+17k.
  - With defaults, entry 31 is written in cycle 528, done is high in cycle 529, and busy is high in cycles 1..529.
- wr_en is high for exactly 2^DIGIT_BITS cycles per run, with addresses strictly ascending 0..31.
- A new start is accepted on the first IDLE cycle after done.

## Structure
- Package xpb_pkg holds:
  - the DIGIT_BITS, WORD_W and LIMB_W defaults and the derived NLIMB;
  - the state enum xpb_gen_state_t (IDLE, WR0, ADD, WRITE, DONE).
- Sub-module limb_addsub: combinational LIMB_W adder plus subtractor.
  - Inputs: a, b, m, cin, bin.
  - Outputs: s, cout, d, bout.
- The top level contains the FSM, the limb index and k counters, and the acc/sum_r/diff_r shift registers.

## Test plan
- M=97, base=40, start → wr_data for addresses 0..5 = 0, 40, 80, 23, 63, 6; all 32 entries match (40k mod 97); done at cycle 529.
- M=100, base=50 → entries alternate 0, 50, 0, 50, …; exercises the exact sum==M case giving 0.
- M=2^1024−1, base=2^1023 → entry1=2^1023, entry2=1 (carry-out path), entry3=2^1023+1; all entries checked against a reference model.
- base=0, arbitrary M → 32 writes of 0, correct addresses, then a single done pulse.
- start re-asserted at cycles 5 and 300 of a run → ignored; the write sequence and done timing are unchanged.
- rst_n low at cycle 200 (mid-ADD) → all outputs 0 and no further writes. A fresh start after release gives a full correct sequence from entry 0.
